// File: rtl/fifo_rd_packer_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_packer_if
//   Output word stream of the FIFO read-side byte packer.
//
//   m_valid  word present on m_data/m_keep/m_last
//   m_ready  downstream accepts the word this cycle
//   m_data   packed word, first byte in [7:0]
//   m_keep   byte-lane enables for m_data
//   m_last   word was produced by a flush
//
//   master : the packer (drives the word, samples m_ready)
//   slave  : the consumer
// ---------------------------------------------------------------------------
interface fifo_rd_packer_if;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_keep,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_keep,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// ---------------------------------------------------------------------------
// fifo_rd_packer
//   Pops bytes from the read side of an 8-bit FIFO (registered read data,
//   latency 1) and packs them little-endian into 32-bit words. A flush
//   request emits any partial word with a shortened m_keep and m_last=1.
//
//   r_clk       sole clock, rising edge
//   r_rst       synchronous, active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  FIFO pop request
//   flush       single-cycle request to emit a partial word
//   m_if        output word stream (master side)
//   flush_done  one-cycle pulse when a flush completes
//   word_cnt    count of accepted output words (wraps)
// ---------------------------------------------------------------------------
module fifo_rd_packer (
    input  logic             r_clk,
    input  logic             r_rst,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_rd_en,
    input  logic             flush,
    fifo_rd_packer_if.master m_if,
    output logic             flush_done,
    output logic [15:0]      word_cnt
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;

    logic [1:0]  state;
    logic [31:0] acc;
    logic [2:0]  acc_cnt;
    logic        inflight;

    logic        m_valid_q;
    logic [31:0] m_data_q;
    logic [3:0]  m_keep_q;
    logic        m_last_q;

    logic        out_free;
    logic [2:0]  eff_cnt;
    logic [31:0] acc_nx;
    logic        full_load;
    logic        emit_load;
    logic [3:0]  emit_keep;
    logic [31:0] emit_mask;

    assign out_free = ~m_valid_q | m_if.m_ready;

    // Bytes held plus the byte landing this cycle (if a read is outstanding).
    assign eff_cnt = acc_cnt + {2'b00, inflight};

    // A read may be issued while the accumulator has room for its byte, or
    // when the output register can take the current word this very edge.
    assign fifo_rd_en = ~r_rst & ~fifo_empty & (state == ST_RUN)
                      & ((eff_cnt < 3'd4) | out_free);

    // A full word moves to the output in RUN, and in DRAIN only together with
    // the last landing byte; a full word already held when DRAIN settles goes
    // out through EMIT as the flush word.
    assign full_load = (eff_cnt == 3'd4) & out_free
                     & ((state == ST_RUN) | ((state == ST_DRAIN) & inflight));
    assign emit_load = (state == ST_EMIT) & out_free;

    always_comb begin
        // NOTE: every output of this block gets a default before any condition,
        // so no path leaves a value unassigned and no latch is inferred.
        acc_nx    = acc;
        emit_keep = 4'hF;
        if (inflight) begin
            acc_nx[{acc_cnt[1:0], 3'b000} +: 8] = fifo_data;
        end
        case (acc_cnt)
            3'd1:    emit_keep = 4'b0001;
            3'd2:    emit_keep = 4'b0011;
            3'd3:    emit_keep = 4'b0111;
            default: emit_keep = 4'hF;
        endcase
        emit_mask = {{8{emit_keep[3]}}, {8{emit_keep[2]}},
                     {8{emit_keep[1]}}, {8{emit_keep[0]}}};
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state      <= ST_RUN;
            acc        <= '0;
            acc_cnt    <= '0;
            inflight   <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
            flush_done <= 1'b0;
            word_cnt   <= '0;
        end else begin
            inflight   <= fifo_rd_en;
            acc        <= acc_nx;
            acc_cnt    <= eff_cnt;
            flush_done <= 1'b0;

            if (m_valid_q && m_if.m_ready) begin
                m_valid_q <= 1'b0;
                word_cnt  <= word_cnt + 16'd1;
            end

            // A load overrides the drop above: accept and reload in one edge.
            if (full_load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= acc_nx;
                m_keep_q  <= 4'hF;
                m_last_q  <= 1'b0;
                acc_cnt   <= 3'd0;
            end else if (emit_load) begin
                m_valid_q  <= 1'b1;
                m_data_q   <= acc & emit_mask;
                m_keep_q   <= emit_keep;
                m_last_q   <= 1'b1;
                acc_cnt    <= 3'd0;
                flush_done <= 1'b1;
            end

            case (state)
                ST_RUN: begin
                    if (flush) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!inflight) begin
                        if (acc_cnt != 3'd0) begin
                            state <= ST_EMIT;
                        end else begin
                            flush_done <= 1'b1;
                            state      <= ST_RUN;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_free) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign m_if.m_valid = m_valid_q;
    assign m_if.m_data  = m_data_q;
    assign m_if.m_keep  = m_keep_q;
    assign m_if.m_last  = m_last_q;

    // The read gating never lets a byte land while a full word is parked in
    // the accumulator, so a full accumulator cannot overflow.
    a_no_land_on_full: assert property (
        @(posedge r_clk) disable iff (r_rst) (acc_cnt == 3'd4) |-> !inflight
    );

    a_acc_cnt_range: assert property (
        @(posedge r_clk) disable iff (r_rst) acc_cnt <= 3'd4
    );

endmodule
